tmr_fault_recovery_ctrl: RTL

Recovery sequencer for the triple-redundant processor cluster, placed between the TMR voter's fault outputs and the per-core reset inputs. It debounces the voter's per-core fault flags and, once a single-core fault is confirmed, pulses that core's reset. It then waits for the core to resynchronise and re-checks the core. Retries are bounded; a core that keeps failing is retired, and a multi-core fault is escalated as fatal. Fault counters and an optional fault timestamp feed the LED/status logic.

---
 rtl/tmr_recovery_pkg.sv | 54 +++++
 rtl/tmr_fault_recovery_ctrl_sat_counter.sv | 46 ++++
 rtl/tmr_fault_recovery_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tmr_recovery_pkg.sv
// -----------------------------------------------------------------------------
// tmr_recovery_pkg
// Shared types and helpers for the TMR fault recovery sequencer.
//   - state_t     : recovery FSM states
//   - NUM_CORES   : number of redundant cores in the cluster
//   - core_idx_t  : 2-bit core index
//   - popcount3 / core_onehot / onehot_index : small flag-vector helpers
// No ports (package).
// -----------------------------------------------------------------------------
package tmr_recovery_pkg;

    localparam int NUM_CORES = 3;

    typedef logic [1:0] core_idx_t;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CONFIRM    = 3'd1,
        RESET_CORE = 3'd2,
        RESYNC     = 3'd3,
        CHECK      = 3'd4,
        HALT       = 3'd5
    } state_t;

    // Number of set bits in a 3-bit flag vector.
    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // One-hot vector selecting the given core; index 3 selects nothing.
    function automatic logic [2:0] core_onehot(input core_idx_t idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Index of the set bit of a one-hot vector (caller guarantees one-hot).
    function automatic core_idx_t onehot_index(input logic [2:0] v);
        core_idx_t idx;
        case (v)
            3'b001:  idx = 2'd0;
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/tmr_fault_recovery_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// tmr_sat_counter
// Saturating up-counter used for the per-core confirmed-fault counts.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (priority over increment)
//   inc_i      : increment by one, holding at all-ones
//   cnt_o      : registered count value
// -----------------------------------------------------------------------------
module tmr_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !(&cnt_q)) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tmr_fault_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// tmr_fault_recovery_ctrl
// Recovery sequencer between the TMR voter fault flags and the per-core
// resets. A single-core fault that persists is confirmed, the core is reset,
// allowed to resynchronise and re-checked; repeated failures retire the core,
// and simultaneous faults on two or more live cores halt the sequencer.
//
// Optional feature macro: TMR_RECOVERY_TIMESTAMP_EN
//   defined   -> last_fault_time_o holds voted_time_count_i at the last
//                confirmation (cleared by clear_status_i)
//   undefined -> last_fault_time_o is tied to zero
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   recovery_en_i       : allow automatic core resets
//   fault_flags_i[2:0]  : voter disagreement flag per core
//   voted_time_count_i  : voted MTIME for fault timestamps
//   clear_status_i      : clear counters / retired mask / fatal, return to IDLE
//   core_resetn_o[2:0]  : per-core reset request, active-low
//   recovery_busy_o     : sequencer not idle
//   core_retired_o[2:0] : cores that used up their retries
//   fatal_fault_o       : multi-core fault seen
//   fault_cnt_o         : saturating confirmed-fault counters, CNT_W per core
//   fault_irq_o         : one-cycle pulse per confirmation
//   last_fault_time_o   : timestamp of the last confirmation
// -----------------------------------------------------------------------------
module tmr_fault_recovery_ctrl
    import tmr_recovery_pkg::*;
#(
    parameter int PERSIST_CYCLES = 16,
    parameter int RESET_CYCLES   = 64,
    parameter int RESYNC_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 3,
    parameter int CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 recovery_en_i,
    input  logic [2:0]           fault_flags_i,
    input  logic [63:0]          voted_time_count_i,
    input  logic                 clear_status_i,
    output logic [2:0]           core_resetn_o,
    output logic                 recovery_busy_o,
    output logic [2:0]           core_retired_o,
    output logic                 fatal_fault_o,
    output logic [3*CNT_W-1:0]   fault_cnt_o,
    output logic                 fault_irq_o,
    output logic [63:0]          last_fault_time_o
);

    localparam int MAX_CYC = (RESET_CYCLES > RESYNC_CYCLES) ? RESET_CYCLES : RESYNC_CYCLES;
    localparam int CYC_W   = $clog2(MAX_CYC + 1);
    localparam int PER_W   = $clog2(PERSIST_CYCLES + 1);

    localparam logic [PER_W-1:0] PERSIST_LAST   = PER_W'(PERSIST_CYCLES - 1);
    localparam logic [CYC_W-1:0] RESET_END      = CYC_W'(RESET_CYCLES);
    localparam logic [CYC_W-1:0] RESYNC_LAST    = CYC_W'(RESYNC_CYCLES - 1);
    localparam logic [3:0]       MAX_RETRY_LAST = 4'(MAX_RETRIES - 1);

    state_t            state_q, state_d;
    core_idx_t         tgt_q, tgt_d;
    logic [PER_W-1:0]  persist_q, persist_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [2:0]        resetn_q, resetn_d;
    logic [2:0]        retired_q, retired_d;
    logic              fatal_q, fatal_d;
    logic              irq_q, irq_d;
    logic              busy_q;
    logic [3:0]        retry_q [NUM_CORES];
    logic [3:0]        retry_d [NUM_CORES];

    logic [2:0]        rec_mask_s;
    logic [2:0]        eff_flags_s;
    logic [1:0]        eff_pop_s;
    logic              start_s;
    core_idx_t         start_idx_s;
    logic              confirm_s;
    logic              capture_s;
    logic [2:0]        cnt_inc_s;
    logic              cnt_clr_s;

    // Effective flags: retired cores and the core under reset/resync are ignored.
    always_comb begin
        rec_mask_s = 3'b000;
        if ((state_q == RESET_CORE) || (state_q == RESYNC)) begin
            rec_mask_s = core_onehot(tgt_q);
        end else begin
            rec_mask_s = 3'b000;
        end
        eff_flags_s = fault_flags_i & ~retired_q & ~rec_mask_s;
        eff_pop_s   = popcount3(eff_flags_s);
    end

    // Recovery FSM next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        persist_d   = persist_q;
        cyc_d       = cyc_q;
        resetn_d    = resetn_q;
        retired_d   = retired_q;
        fatal_d     = fatal_q;
        retry_d     = retry_q;
        irq_d       = 1'b0;
        start_s     = 1'b0;
        start_idx_s = tgt_q;
        confirm_s   = 1'b0;
        capture_s   = 1'b0;
        cnt_inc_s   = 3'b000;
        cnt_clr_s   = 1'b0;

        if (clear_status_i) begin
            state_d   = IDLE;
            persist_d = '0;
            cyc_d     = '0;
            resetn_d  = 3'b111;
            retired_d = 3'b000;
            fatal_d   = 1'b0;
            cnt_clr_s = 1'b1;
            for (int i = 0; i < NUM_CORES; i++) begin
                retry_d[i] = 4'd0;
            end
        end else if ((state_q != HALT) && (eff_pop_s >= 2'd2)) begin
            // Two live cores disagreeing at once cannot be outvoted: stop.
            fatal_d   = 1'b1;
            state_d   = HALT;
            resetn_d  = 3'b111;
            persist_d = '0;
            cyc_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (eff_pop_s == 2'd1) begin
                        start_s     = 1'b1;
                        start_idx_s = onehot_index(eff_flags_s);
                    end else begin
                        state_d = IDLE;
                    end
                end
                CONFIRM: begin
                    if (eff_flags_s == core_onehot(tgt_q)) begin
                        if (persist_q == PERSIST_LAST) begin
                            confirm_s = 1'b1;
                        end else begin
                            persist_d = persist_q + PER_W'(1);
                        end
                    end else begin
                        state_d   = IDLE;
                        persist_d = '0;
                    end
                end
                RESET_CORE: begin
                    // cyc_q counts reset-low cycles already issued.
                    if (cyc_q == RESET_END) begin
                        resetn_d = 3'b111;
                        cyc_d    = '0;
                        state_d  = RESYNC;
                    end else begin
                        resetn_d = ~core_onehot(tgt_q);
                        cyc_d    = cyc_q + CYC_W'(1);
                    end
                end
                RESYNC: begin
                    if (cyc_q == RESYNC_LAST) begin
                        cyc_d   = '0;
                        state_d = CHECK;
                    end else begin
                        cyc_d = cyc_q + CYC_W'(1);
                    end
                end
                CHECK: begin
                    if (!fault_flags_i[tgt_q]) begin
                        retry_d[tgt_q] = 4'd0;
                        state_d        = IDLE;
                    end else if (retry_q[tgt_q] == MAX_RETRY_LAST) begin
                        retired_d[tgt_q] = 1'b1;
                        retry_d[tgt_q]   = 4'd0;
                        state_d          = IDLE;
                    end else begin
                        // This cycle already counts as the first persisting one.
                        retry_d[tgt_q] = retry_q[tgt_q] + 4'd1;
                        start_s        = 1'b1;
                        start_idx_s    = tgt_q;
                    end
                end
                HALT: begin
                    resetn_d = 3'b111;
                    state_d  = HALT;
                end
                default: begin
                    resetn_d = 3'b111;
                    state_d  = IDLE;
                end
            endcase

            // First flagged cycle of a candidate fault.
            if (start_s) begin
                tgt_d = start_idx_s;
                if (PERSIST_CYCLES == 1) begin
                    confirm_s = 1'b1;
                end else begin
                    persist_d = PER_W'(1);
                    state_d   = CONFIRM;
                end
            end else begin
                tgt_d = tgt_q;
            end

            // Fault confirmed: report it and optionally start the reset.
            if (confirm_s) begin
                irq_d     = 1'b1;
                capture_s = 1'b1;
                cnt_inc_s = core_onehot(tgt_d);
                persist_d = '0;
                cyc_d     = '0;
                state_d   = recovery_en_i ? RESET_CORE : IDLE;
            end else begin
                irq_d = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tgt_q     <= 2'd0;
            persist_q <= '0;
            cyc_q     <= '0;
            resetn_q  <= 3'b111;
            retired_q <= 3'b000;
            fatal_q   <= 1'b0;
            irq_q     <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                retry_q[i] <= 4'd0;
            end
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            persist_q <= persist_d;
            cyc_q     <= cyc_d;
            resetn_q  <= resetn_d;
            retired_q <= retired_d;
            fatal_q   <= fatal_d;
            irq_q     <= irq_d;
            busy_q    <= (state_d != IDLE);
            for (int i = 0; i < NUM_CORES; i++) begin
                retry_q[i] <= retry_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_cnt
        tmr_sat_counter #(
            .W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (cnt_clr_s),
            .inc_i (cnt_inc_s[g]),
            .cnt_o (fault_cnt_o[g*CNT_W +: CNT_W])
        );
    end

`ifdef TMR_RECOVERY_TIMESTAMP_EN
    logic [63:0] time_q;

    // Timestamp of the most recent confirmed fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_q <= 64'd0;
        end else if (clear_status_i) begin
            time_q <= 64'd0;
        end else if (capture_s) begin
            time_q <= voted_time_count_i;
        end else begin
            time_q <= time_q;
        end
    end

    assign last_fault_time_o = time_q;
`else
    logic unused_time_s;
    assign unused_time_s     = ^{voted_time_count_i, capture_s};
    assign last_fault_time_o = 64'd0;
`endif

    assign core_resetn_o   = resetn_q;
    assign recovery_busy_o = busy_q;
    assign core_retired_o  = retired_q;
    assign fatal_fault_o   = fatal_q;
    assign fault_irq_o     = irq_q;

endmodule
